// File: rtl/cplx_pkg.sv
// Shared types and constants for the complex add/sub arbiter slice.
// Complex words are packed {re, im} with re in the upper half.
package cplx_pkg;

  localparam int unsigned PART_LEN = 8;

  typedef struct packed {
    logic [PART_LEN-1:0] re;
    logic [PART_LEN-1:0] im;
  } cplx_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

endpackage : cplx_pkg

// File: rtl/cplx_addsub.sv
// Combinational complex add/sub: the real and imaginary parts have separate
// adders, so no carry or borrow ever crosses from the imaginary into the real part.
module cplx_addsub
  import cplx_pkg::*;
#(
  parameter int unsigned PART_LEN = cplx_pkg::PART_LEN
) (
  input  logic [2*PART_LEN-1:0] a,
  input  logic [2*PART_LEN-1:0] b,
  input  logic                  asn,
  output logic [2*PART_LEN-1:0] y
);

  logic [PART_LEN-1:0] a_re, a_im, b_re, b_im;
  logic [PART_LEN-1:0] y_re, y_im;

  assign a_re = a[2*PART_LEN-1:PART_LEN];
  assign a_im = a[PART_LEN-1:0];
  assign b_re = b[2*PART_LEN-1:PART_LEN];
  assign b_im = b[PART_LEN-1:0];

  // Results are truncated to PART_LEN, giving modulo-2^PART_LEN wrap per part.
  always_comb begin
    if (asn == OP_ADD) begin
      y_re = a_re + b_re;
      y_im = a_im + b_im;
    end else begin
      y_re = a_re - b_re;
      y_im = a_im - b_im;
    end
  end

  assign y = {y_re, y_im};

endmodule : cplx_addsub

// File: rtl/cplx_as_arbiter.sv
// Round-robin arbiter sharing one complex add/sub datapath between two
// requesters, with a 1-deep result register on a valid/ready response channel.
module cplx_as_arbiter
  import cplx_pkg::*;
#(
  parameter int unsigned PART_LEN = cplx_pkg::PART_LEN,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [2*PART_LEN-1:0] req0_a,
  input  logic [2*PART_LEN-1:0] req0_b,
  input  logic                  req0_asn,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [2*PART_LEN-1:0] req1_a,
  input  logic [2*PART_LEN-1:0] req1_b,
  input  logic                  req1_asn,

  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*PART_LEN-1:0] res_data,
  output logic                  res_id,
  output logic [CNT_W-1:0]      op_cnt
);

  req_id_e               last_grant;
  req_id_e               grant_id;
  logic                  grant_valid;
  logic                  slot_free;
  logic                  consume;
  logic [2*PART_LEN-1:0] mux_a, mux_b;
  logic                  mux_asn;
  logic [2*PART_LEN-1:0] op_result;

  // The slot frees up in the same cycle the consumer takes the old result,
  // which is what allows one accepted op per cycle.
  assign slot_free = !res_valid || res_ready;
  assign consume   = res_valid && res_ready;

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ0;
    if (rstn && slot_free) begin
      unique case ({req1_valid, req0_valid})
        2'b01: begin
          grant_valid = 1'b1;
          grant_id    = REQ0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_id    = REQ1;
        end
        2'b11: begin
          grant_valid = 1'b1;
          grant_id    = (last_grant == REQ0) ? REQ1 : REQ0;
        end
        default: begin
          grant_valid = 1'b0;
          grant_id    = REQ0;
        end
      endcase
    end
  end

  assign req0_ready = grant_valid && (grant_id == REQ0);
  assign req1_ready = grant_valid && (grant_id == REQ1);

  // Only the granted requester's operands reach the shared datapath.
  always_comb begin
    if (grant_id == REQ1) begin
      mux_a   = req1_a;
      mux_b   = req1_b;
      mux_asn = req1_asn;
    end else begin
      mux_a   = req0_a;
      mux_b   = req0_b;
      mux_asn = req0_asn;
    end
  end

  cplx_addsub #(
    .PART_LEN (PART_LEN)
  ) u_addsub (
    .a   (mux_a),
    .b   (mux_b),
    .asn (mux_asn),
    .y   (op_result)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
      op_cnt     <= '0;
      last_grant <= REQ1;
    end else begin
      if (consume) begin
        op_cnt <= op_cnt + 1'b1;
      end
      if (grant_valid) begin
        res_data   <= op_result;
        res_id     <= grant_id;
        res_valid  <= 1'b1;
        last_grant <= grant_id;
      end else if (consume) begin
        res_valid  <= 1'b0;
      end
    end
  end

endmodule : cplx_as_arbiter

// File: tb/tb_cplx_as_arbiter.sv
// Directed bench for cplx_as_arbiter: arithmetic, fairness, backpressure,
// mid-operation reset and counter wrap on a narrow-counter second instance.
module tb_cplx_as_arbiter;
  import cplx_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req0_ready, req0_asn;
  logic        req1_valid, req1_ready, req1_asn;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready, res_id;
  logic [15:0] res_data;
  logic [15:0] op_cnt;

  logic        w_req0_valid, w_req0_ready, w_req1_ready;
  logic        w_res_valid, w_res_ready, w_res_id;
  logic [15:0] w_res_data;
  logic [3:0]  w_op_cnt;
  logic [15:0] w_zero = 16'h0000;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cplx_as_arbiter #(.PART_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_asn(req0_asn),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_asn(req1_asn),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .op_cnt(op_cnt)
  );

  cplx_as_arbiter #(.PART_LEN(8), .CNT_W(4)) dut_w (
    .clk(clk), .rstn(rstn),
    .req0_valid(w_req0_valid), .req0_ready(w_req0_ready),
    .req0_a(16'h0102), .req0_b(16'h0101), .req0_asn(OP_ADD),
    .req1_valid(1'b0), .req1_ready(w_req1_ready),
    .req1_a(w_zero), .req1_b(w_zero), .req1_asn(OP_SUB),
    .res_valid(w_res_valid), .res_ready(w_res_ready),
    .res_data(w_res_data), .res_id(w_res_id), .op_cnt(w_op_cnt)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester protocol: a waiting requester must keep its operands stable.
  logic        p0_wait, p1_wait;
  logic [32:0] p0_op, p1_op;
  always @(posedge clk) begin
    if (p0_wait && req0_valid) check("hold0", {req0_asn, req0_a, req0_b}, p0_op);
    if (p1_wait && req1_valid) check("hold1", {req1_asn, req1_a, req1_b}, p1_op);
    p0_wait <= rstn && req0_valid && !req0_ready;
    p1_wait <= rstn && req1_valid && !req1_ready;
    p0_op   <= {req0_asn, req0_a, req0_b};
    p1_op   <= {req1_asn, req1_a, req1_b};
  end

  initial begin
    cplx_t exp_c;
    p0_wait = 1'b0; p1_wait = 1'b0;
    rstn = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_asn = OP_SUB;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_asn = OP_SUB;
    w_req0_valid = 1'b0; w_res_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_valid", res_valid, 0);
    check("rst_data",  res_data, 0);
    check("rst_id",    res_id, 0);
    check("rst_cnt",   op_cnt, 0);
    req0_valid = 1'b1; #1;
    check("rst_ready0", req0_ready, 0);
    req0_valid = 1'b0;

    // Add from req0
    rstn = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0305; req0_b = 16'h0102; req0_asn = OP_ADD;
    #1;
    check("add_ready0", req0_ready, 1);
    check("add_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    check("add_valid", res_valid, 1);
    check("add_data",  res_data, 16'h0407);
    check("add_id",    res_id, 0);

    // Sub from req1, consumed and accepted on the same edge
    res_ready = 1'b1;
    req1_valid = 1'b1; req1_a = 16'h0305; req1_b = 16'h0102; req1_asn = OP_SUB;
    #1;
    check("sub_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    check("sub_valid", res_valid, 1);
    check("sub_data",  res_data, 16'h0203);
    check("sub_id",    res_id, 1);
    check("sub_cnt",   op_cnt, 1);

    // Imaginary part wraps without carrying into the real part
    req0_valid = 1'b1; req0_a = 16'h7F80; req0_b = 16'h0180; req0_asn = OP_ADD;
    tick();
    req0_valid = 1'b0;
    exp_c.re = 8'h80; exp_c.im = 8'h00;
    check("wrap_data", res_data, exp_c);
    check("wrap_id",   res_id, 0);

    // Consume without accept: data and id hold
    tick();
    check("drain_valid", res_valid, 0);
    check("drain_data",  res_data, 16'h8000);
    check("drain_cnt",   op_cnt, 3);

    // Contention after reset: grants alternate 0,1,0,1
    rstn = 1'b0; tick(); rstn = 1'b1;
    check("c_rst_cnt", op_cnt, 0);
    req0_a = 16'h0101; req0_b = 16'h0101; req0_asn = OP_ADD;
    req1_a = 16'h1010; req1_b = 16'h0101; req1_asn = OP_SUB;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    tick(); check("c1_id", res_id, 0); check("c1_data", res_data, 16'h0202);
    tick(); check("c2_id", res_id, 1); check("c2_data", res_data, 16'h0F0F);
    tick(); check("c3_id", res_id, 0);
    tick(); check("c4_id", res_id, 1);
    tick(); check("c5_id", res_id, 0);
    check("c_cnt4", op_cnt, 4);

    // Backpressure: result held, nobody granted
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready0", req0_ready, 0);
      check("bp_ready1", req1_ready, 0);
      tick();
      check("bp_valid", res_valid, 1);
      check("bp_data",  res_data, 16'h0202);
      check("bp_id",    res_id, 0);
    end
    res_ready = 1'b1; #1;
    check("bp_rel_ready1", req1_ready, 1);
    tick();
    check("bp_rel_valid", res_valid, 1);
    check("bp_rel_id",    res_id, 1);
    check("bp_rel_data",  res_data, 16'h0F0F);
    check("bp_rel_cnt",   op_cnt, 5);

    // Reset while a result is stalled
    res_ready = 1'b0; tick();
    rstn = 1'b0; #1;
    check("mr_ready0", req0_ready, 0);
    check("mr_ready1", req1_ready, 0);
    tick();
    check("mr_valid", res_valid, 0);
    check("mr_data",  res_data, 0);
    check("mr_cnt",   op_cnt, 0);
    rstn = 1'b1; res_ready = 1'b1; #1;
    check("mr_first0", req0_ready, 1);
    tick();
    check("mr_id", res_id, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Narrow counter wraps modulo 16
    check("w_cnt0", w_op_cnt, 0);
    w_req0_valid = 1'b1; w_res_ready = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    check("w_cnt16", w_op_cnt, 0);
    check("w_data", w_res_data, 16'h0203);
    w_req0_valid = 1'b0;
    tick();
    check("w_cnt17", w_op_cnt, 1);
    check("w_valid", w_res_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cplx_as_arbiter
